// File: rtl/ofdm_rx_pkg.sv
// ofdm_rx_pkg
// Shared definitions for the OFDM receive path: the frame scheduler state
// encoding and the default frame geometry used by the scheduler, symbol
// extraction and FFT stages.
package ofdm_rx_pkg;

  // PeakFinded-high cycles before the first LTS useful sample
  // (LTS cyclic prefix of 32 minus the 10-cycle processing delay).
  localparam int LTS_DELAY_DEF = 22;
  // Useful samples per OFDM symbol.
  localparam int SYM_LEN_DEF   = 64;
  // Cyclic-prefix samples per data symbol; also the drain length.
  localparam int CP_LEN_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LTS_WAIT,
    ST_LTS,
    ST_DATA,
    ST_DRAIN
  } sched_state_t;

endpackage

// File: rtl/rx_symbol_scheduler.sv
// rx_symbol_scheduler
// Frame-level sequencer for the OFDM receive path. Converts the one-cycle
// SyncDetect pulse from the timing-sync block into the PeakFinded window for
// symbol extraction, tags each useful sample with its symbol number and
// sample index, and reports frame completion or abort.
//
// Ports:
//   Clk         in   clock
//   Rst_n       in   asynchronous active-low reset
//   SyncDetect  in   one-cycle pulse at the end of the STS
//   CfgSymbols  in   number of data symbols (sampled on accepted SyncDetect)
//   Abort       in   one-cycle abort pulse (e.g. carrier lost)
//   PeakFinded  out  frame window enable to symbol extraction
//   SymValid    out  high on useful-sample cycles
//   SymStart    out  pulse on the first useful sample of each symbol
//   SymIndex    out  sample index within the symbol, 0 outside windows
//   SymNum      out  0 = LTS, 1..CfgSymbols = data symbol
//   Busy        out  frame in progress
//   FrameDone   out  one-cycle pulse on normal completion
//   FrameErr    out  one-cycle pulse on abort
module rx_symbol_scheduler
  import ofdm_rx_pkg::*;
#(
  parameter int LTS_DELAY = LTS_DELAY_DEF,
  parameter int SYM_LEN   = SYM_LEN_DEF,
  parameter int CP_LEN    = CP_LEN_DEF
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       SyncDetect,
  input  logic [7:0] CfgSymbols,
  input  logic       Abort,
  output logic       PeakFinded,
  output logic       SymValid,
  output logic       SymStart,
  output logic [5:0] SymIndex,
  output logic [7:0] SymNum,
  output logic       Busy,
  output logic       FrameDone,
  output logic       FrameErr
);

  localparam logic [6:0] WAIT_LAST   = 7'(LTS_DELAY - 1);
  localparam logic [6:0] SYM_LAST    = 7'(SYM_LEN - 1);
  localparam logic [6:0] PERIOD_LAST = 7'(SYM_LEN + CP_LEN - 1);
  localparam logic [6:0] DRAIN_LAST  = 7'(CP_LEN - 1);
  localparam logic [6:0] USEFUL_END  = 7'(SYM_LEN);

  sched_state_t state, state_d;
  logic [6:0]   cnt, cnt_d;
  logic [7:0]   sym, sym_d;
  logic [7:0]   nsym, nsym_d;

  logic       peak_d, valid_d, start_d, busy_d, done_d, err_d;
  logic [5:0] index_d;
  logic [7:0] num_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sym        <= '0;
      nsym       <= '0;
      PeakFinded <= 1'b0;
      SymValid   <= 1'b0;
      SymStart   <= 1'b0;
      SymIndex   <= '0;
      SymNum     <= '0;
      Busy       <= 1'b0;
      FrameDone  <= 1'b0;
      FrameErr   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sym        <= sym_d;
      nsym       <= nsym_d;
      PeakFinded <= peak_d;
      SymValid   <= valid_d;
      SymStart   <= start_d;
      SymIndex   <= index_d;
      SymNum     <= num_d;
      Busy       <= busy_d;
      FrameDone  <= done_d;
      FrameErr   <= err_d;
    end
  end

  // Outputs are decoded from the next-state values so that every output is a
  // flop yet still lines up with the state the frame is entering.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sym_d   = sym;
    nsym_d  = nsym;
    err_d   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (SyncDetect && !Abort) begin
          state_d = ST_LTS_WAIT;
          cnt_d   = '0;
          sym_d   = '0;
          nsym_d  = CfgSymbols;
        end
      end
      ST_LTS_WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_d = ST_LTS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 7'd1;
        end
      end
      ST_LTS: begin
        if (cnt == SYM_LAST) begin
          cnt_d = '0;
          if (nsym != 8'd0) begin
            state_d = ST_DATA;
            sym_d   = 8'd1;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          cnt_d = cnt + 7'd1;
        end
      end
      ST_DATA: begin
        // A period is the useful window followed by the CP of the next
        // symbol, so the last symbol's period ends on a CP-length tail.
        if (cnt == PERIOD_LAST) begin
          cnt_d = '0;
          if (sym == nsym) begin
            state_d = ST_DRAIN;
          end else begin
            sym_d = sym + 8'd1;
          end
        end else begin
          cnt_d = cnt + 7'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sym_d   = '0;
          nsym_d  = '0;
        end else begin
          cnt_d = cnt + 7'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sym_d   = '0;
        nsym_d  = '0;
      end
    endcase

    if (Abort && (state != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sym_d   = '0;
      nsym_d  = '0;
      err_d   = 1'b1;
    end

    peak_d  = (state_d == ST_LTS_WAIT) || (state_d == ST_LTS) || (state_d == ST_DATA);
    valid_d = (state_d == ST_LTS) || ((state_d == ST_DATA) && (cnt_d < USEFUL_END));
    start_d = valid_d && (cnt_d == 7'd0);
    index_d = valid_d ? cnt_d[5:0] : 6'd0;
    // SymNum holds through the CP tail and drain, and reads 0 otherwise.
    num_d   = ((state_d == ST_DATA) || (state_d == ST_DRAIN)) ? sym_d : 8'd0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DRAIN) && (cnt_d == DRAIN_LAST);
  end

endmodule
